divider_unit: RTL

DIVIDER_UNIT -- requirements
Module: divider_unit

---
 rtl/divider_unit_pkg.sv | 40 ++++
 rtl/divider_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/divider_unit_pkg.sv
// Shared constants for the iterative divider: operation codes, FSM
// encodings and the fixed results of the divide-by-zero / overflow cases.
package divider_unit_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned COUNT_W = 5;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam logic [COUNT_W-1:0] LAST_ITER = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_DONE   = 2'd2
  } div_state_t;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

  // Fixed answer for the two corner cases: b == 0 gives all-ones quotient
  // and the dividend as remainder; the signed overflow gives MIN_INT and 0.
  function automatic logic [DATA_W-1:0] special_result(
    input logic [1:0]        op,
    input logic [DATA_W-1:0] a,
    input logic              b_zero
  );
    if (b_zero) return op_is_rem(op) ? a : {DATA_W{1'b1}};
    return op_is_rem(op) ? '0 : {1'b1, {(DATA_W-1){1'b0}}};
  endfunction

endpackage

// File: rtl/divider_unit.sv
// Radix-2 restoring divider, 32 iterations, signed/unsigned quotient and
// remainder, with optional single-cycle completion of corner cases.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start (or holding an early-out result one cycle)
// ST_DIVIDE | iterating, one quotient bit per cycle, then sign fix-up
// ST_DONE   | result_valid cycle; may accept the next start directly
module divider_unit
  import divider_unit_pkg::*;
#(
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  div_op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        flush,
  output logic        busy,
  output logic        result_valid,
  output logic [31:0] result
);

  div_state_t         state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               iter_done_q, iter_done_d;
  logic               early_q, early_d;
  logic [1:0]         op_q, op_d;
  logic [31:0]        a_q, a_d;
  logic               b_zero_q, b_zero_d;
  logic               special_q, special_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [31:0]        divisor_q, divisor_d;
  logic [31:0]        quo_q, quo_d;
  logic [31:0]        rem_q, rem_d;
  logic [31:0]        result_q, result_d;

  logic        accept;
  logic        in_signed;
  logic        in_special;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [32:0] part_rem;
  logic [32:0] diff;
  logic [31:0] final_quo;
  logic [31:0] final_rem;
  logic [31:0] final_res;

  // Next-state, datapath step and result selection.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    iter_done_d = iter_done_q;
    early_d     = early_q;
    op_d        = op_q;
    a_d         = a_q;
    b_zero_d    = b_zero_q;
    special_d   = special_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    divisor_d   = divisor_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    result_d    = result_q;

    // An early-out pending in IDLE owns the next edge, so start waits.
    accept = start && !flush &&
             (((state_q == ST_IDLE) && !early_q) || (state_q == ST_DONE));

    in_signed  = op_is_signed(div_op);
    in_special = (operand_b == '0) ||
                 (in_signed && (operand_a == 32'h8000_0000) &&
                  (operand_b == 32'hFFFF_FFFF));
    a_abs = (in_signed && operand_a[31]) ? (~operand_a + 32'd1) : operand_a;
    b_abs = (in_signed && operand_b[31]) ? (~operand_b + 32'd1) : operand_b;

    // 33-bit partial remainder: previous remainder with next dividend bit.
    part_rem = {rem_q, quo_q[31]};
    diff     = part_rem - {1'b0, divisor_q};

    final_quo = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
    final_rem = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
    if (special_q) final_res = special_result(op_q, a_q, b_zero_q);
    else           final_res = op_is_rem(op_q) ? final_rem : final_quo;

    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          early_d = 1'b0;
        end else if (early_q) begin
          state_d  = ST_DONE;
          result_d = special_result(op_q, a_q, b_zero_q);
          early_d  = 1'b0;
        end
      end
      ST_DIVIDE: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (iter_done_q) begin
          state_d  = ST_DONE;
          result_d = final_res;
        end else begin
          if (!diff[32]) begin
            rem_d = diff[31:0];
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = part_rem[31:0];
            quo_d = {quo_q[30:0], 1'b0};
          end
          if (count_q == LAST_ITER) iter_done_d = 1'b1;
          else                      count_d     = count_q + 5'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept) begin
      op_d        = div_op;
      a_d         = operand_a;
      b_zero_d    = (operand_b == '0);
      special_d   = in_special;
      neg_quo_d   = in_signed && (operand_a[31] ^ operand_b[31]);
      neg_rem_d   = in_signed && operand_a[31];
      divisor_d   = b_abs;
      quo_d       = a_abs;
      rem_d       = '0;
      count_d     = '0;
      iter_done_d = 1'b0;
      if (EARLY_OUT && in_special) begin
        early_d = 1'b1;
        state_d = ST_IDLE;
      end else begin
        state_d = ST_DIVIDE;
      end
    end
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      iter_done_q <= 1'b0;
      early_q     <= 1'b0;
      op_q        <= DIV_OP_DIV;
      a_q         <= '0;
      b_zero_q    <= 1'b0;
      special_q   <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      divisor_q   <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      iter_done_q <= iter_done_d;
      early_q     <= early_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_zero_q    <= b_zero_d;
      special_q   <= special_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      divisor_q   <= divisor_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      result_q    <= result_d;
    end
  end

  assign busy         = (state_q == ST_DIVIDE);
  assign result_valid = (state_q == ST_DONE);
  assign result       = result_q;

endmodule
